// File: rtl/console_pkg.sv
// rtl/console_pkg.sv - shared geometry, control codes and FSM states for the console stream writer
package console_pkg;

    localparam int NUM_ROWS         = 3;
    localparam int NUM_COLS         = 10;
    localparam int CHARS_ADDR_WIDTH = $clog2(NUM_ROWS * NUM_COLS);
    localparam int COL_WIDTH        = $clog2(NUM_COLS);
    localparam int ROW_WIDTH        = $clog2(NUM_ROWS);

    // Colour used for blanks, BGR bit order as in the console
    localparam logic [2:0] DEFAULT_COLOR = 3'b010;

    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_SPACE = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PUT    = 3'd1,
        ST_ADV    = 3'd2,
        ST_SCROLL = 3'd3,
        ST_BLANK  = 3'd4,
        ST_CLRALL = 3'd5
    } state_t;

endpackage

// File: rtl/console_addr_calc.sv
// rtl/console_addr_calc.sv - row*NUM_COLS+col as a shift-add over the constant column count
module console_addr_calc
    import console_pkg::*;
(
    input  logic [ROW_WIDTH-1:0]        row,
    input  logic [COL_WIDTH-1:0]        col,
    output logic [CHARS_ADDR_WIDTH-1:0] addr
);

    localparam logic [31:0] COLS_VEC = 32'(NUM_COLS);

    logic [CHARS_ADDR_WIDTH-1:0] row_ext;
    logic [CHARS_ADDR_WIDTH-1:0] row_term;

    assign row_ext = CHARS_ADDR_WIDTH'(row);

    // Sum row shifted by each set bit of NUM_COLS; folds to a few adders for a constant
    always_comb begin
        row_term = '0;
        for (int b = 0; b < CHARS_ADDR_WIDTH; b++) begin
            if (COLS_VEC[b]) begin
                row_term = row_term + (row_ext << b);
            end
        end
    end

    assign addr = row_term + CHARS_ADDR_WIDTH'(col);

endmodule

// File: rtl/console_stream_writer.sv
// rtl/console_stream_writer.sv - byte stream to text buffer writer with cursor, scroll and clear (CONSOLE_AUTOWRAP_EN enables right-edge wrap)
module console_stream_writer
    import console_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [7:0]                  in_data,
    input  logic [2:0]                  in_color,
    output logic                        in_ready,
    output logic [CHARS_ADDR_WIDTH-1:0] buf_waddr,
    output logic [6:0]                  buf_wchar,
    output logic [2:0]                  buf_wcolor,
    output logic                        buf_we,
    output logic [CHARS_ADDR_WIDTH-1:0] buf_raddr,
    input  logic [6:0]                  buf_rchar,
    input  logic [2:0]                  buf_rcolor,
    output logic [COL_WIDTH-1:0]        cursor_col,
    output logic [ROW_WIDTH-1:0]        cursor_row,
    output logic                        busy
);

    localparam logic [COL_WIDTH-1:0]        COL_LAST    = COL_WIDTH'(NUM_COLS - 1);
    localparam logic [ROW_WIDTH-1:0]        ROW_LAST    = ROW_WIDTH'(NUM_ROWS - 1);
    localparam logic [CHARS_ADDR_WIDTH-1:0] ROW_STRIDE  = CHARS_ADDR_WIDTH'(NUM_COLS);
    localparam logic [CHARS_ADDR_WIDTH-1:0] SCROLL_LAST = CHARS_ADDR_WIDTH'((NUM_ROWS - 1) * NUM_COLS - 1);
    localparam logic [CHARS_ADDR_WIDTH-1:0] BLANK_LAST  = CHARS_ADDR_WIDTH'(NUM_COLS - 1);
    localparam logic [CHARS_ADDR_WIDTH-1:0] CLR_LAST    = CHARS_ADDR_WIDTH'(NUM_ROWS * NUM_COLS - 1);

    state_t                      state_q, state_d;
    logic [COL_WIDTH-1:0]        col_q, col_d;
    logic [ROW_WIDTH-1:0]        row_q, row_d;
    logic [CHARS_ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [6:0]                  char_q, char_d;
    logic [2:0]                  color_q, color_d;
    logic [CHARS_ADDR_WIDTH-1:0] cursor_addr;
    logic [CHARS_ADDR_WIDTH-1:0] blank_base;

    console_addr_calc u_cursor_addr (
        .row  (row_q),
        .col  (col_q),
        .addr (cursor_addr)
    );

    console_addr_calc u_blank_base (
        .row  (ROW_LAST),
        .col  ({COL_WIDTH{1'b0}}),
        .addr (blank_base)
    );

    assign cursor_col = col_q;
    assign cursor_row = row_q;
    assign busy       = (state_q != ST_IDLE);

    // State, cursor, sweep index and latched byte registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            idx_q   <= '0;
            char_q  <= '0;
            color_q <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            idx_q   <= idx_d;
            char_q  <= char_d;
            color_q <= color_d;
        end
    end

    // Byte decode, cursor movement and buffer port drive for each state
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        idx_d      = idx_q;
        char_d     = char_q;
        color_d    = color_q;
        in_ready   = 1'b0;
        buf_we     = 1'b0;
        buf_waddr  = '0;
        buf_wchar  = '0;
        buf_wcolor = '0;
        buf_raddr  = '0;

        case (state_q)
            ST_IDLE: begin
                in_ready = !reset;
                if (in_valid && in_ready) begin
                    char_d  = in_data[6:0];
                    color_d = in_color;
                    if (in_data >= 8'h20 && in_data <= 8'h7E) begin
                        state_d = ST_PUT;
                    end else if (in_data == CH_LF) begin
                        col_d = '0;
                        if (row_q < ROW_LAST) begin
                            row_d = row_q + ROW_WIDTH'(1);
                        end else begin
                            state_d = ST_SCROLL;
                            idx_d   = '0;
                        end
                    end else if (in_data == CH_CR) begin
                        col_d = '0;
                    end else if (in_data == CH_BS) begin
                        if (col_q != '0) begin
                            col_d = col_q - COL_WIDTH'(1);
                        end
                    end else if (in_data == CH_FF) begin
                        state_d = ST_CLRALL;
                        idx_d   = '0;
                    end
                end
            end

            ST_PUT: begin
                buf_we     = 1'b1;
                buf_waddr  = cursor_addr;
                buf_wchar  = char_q;
                buf_wcolor = color_q;
                state_d    = ST_IDLE;
                if (col_q < COL_LAST) begin
                    col_d = col_q + COL_WIDTH'(1);
                end else begin
`ifdef CONSOLE_AUTOWRAP_EN
                    col_d = '0;
                    if (row_q < ROW_LAST) begin
                        row_d = row_q + ROW_WIDTH'(1);
                    end else begin
                        state_d = ST_SCROLL;
                        idx_d   = '0;
                    end
`else
                    // Cursor parks on the last column; further printables overwrite it
                    col_d = col_q;
`endif
                end
            end

            ST_ADV: begin
                state_d = ST_IDLE;
            end

            ST_SCROLL: begin
                // Copy cell idx+NUM_COLS down to idx using the same-cycle read port
                buf_raddr  = idx_q + ROW_STRIDE;
                buf_we     = 1'b1;
                buf_waddr  = idx_q;
                buf_wchar  = buf_rchar;
                buf_wcolor = buf_rcolor;
                if (idx_q == SCROLL_LAST) begin
                    idx_d   = '0;
                    state_d = ST_BLANK;
                end else begin
                    idx_d = idx_q + CHARS_ADDR_WIDTH'(1);
                end
            end

            ST_BLANK: begin
                buf_we     = 1'b1;
                buf_waddr  = blank_base + idx_q;
                buf_wchar  = CH_SPACE[6:0];
                buf_wcolor = DEFAULT_COLOR;
                if (idx_q == BLANK_LAST) begin
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q + CHARS_ADDR_WIDTH'(1);
                end
            end

            ST_CLRALL: begin
                buf_we     = 1'b1;
                buf_waddr  = idx_q;
                buf_wchar  = CH_SPACE[6:0];
                buf_wcolor = DEFAULT_COLOR;
                if (idx_q == CLR_LAST) begin
                    idx_d   = '0;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q + CHARS_ADDR_WIDTH'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Reset takes the write port away in the same cycle so an aborted sweep stops cleanly
        if (reset) begin
            buf_we     = 1'b0;
            buf_waddr  = '0;
            buf_wchar  = '0;
            buf_wcolor = '0;
            buf_raddr  = '0;
        end
    end

endmodule
